audio_mixer: RTL
================

AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 Parameter NUM_VOICES, 8, number of voices mixed per frame; legal values 1..8.
REQ-002 clk  input  1  audio clock, 49.152 MHz; the same clock as the I2S transmitter.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 sample_req  input  1  one-clk pulse from the I2S transmitter requesting a new stereo pair.
REQ-005 voice_req  output  1  request to the voice engine for the data of voice voice_idx.
REQ-006 voice_idx  output  3  index of the voice being requested.
REQ-007 voice_valid  input  1  voice engine response; voice_sample, voice_vol_l and voice_vol_r are valid this cycle.
REQ-008 voice_sample  input  16  signed two's-complement voice sample.
REQ-009 voice_vol_l  input  8  unsigned left gain; 256 represents unity.
REQ-010 voice_vol_r  input  8  unsigned right gain; 256 represents unity.
REQ-011 left_out  output  16  signed mixed left sample, which feeds the transmitter's left_in.
REQ-012 right_out  output  16  signed mixed right sample, which feeds the transmitter's right_in.
REQ-013 busy  output  1  high whenever the state machine is not in IDLE.
REQ-014 overrun  output  1  one-clk pulse when sample_req is ignored because a mix is in progress.
REQ-015 clip  output  1  sticky saturation flag (see Configuration).
REQ-016 clip_clr  input  1  clears clip.

Function
REQ-017 The state machine SHALL have the states IDLE, REQ, MAC and DONE.
REQ-018 IDLE: when sample_req=1, the block SHALL clear acc_l and acc_r, set idx to 0 and move to REQ; otherwise it SHALL stay in IDLE.
REQ-019 REQ: voice_req SHALL be 1 and voice_idx SHALL equal idx.
REQ-020 REQ: when voice_valid=1, the block SHALL capture the sample and both gains and move to MAC; otherwise it SHALL hold with voice_req and voice_idx stable.
REQ-021 voice_valid SHALL be ignored in every state except REQ.
REQ-022 MAC: acc_l SHALL add (sample*vol_l)>>>8 and acc_r SHALL add (sample*vol_r)>>>8. Each product is 24-bit signed, the shift is arithmetic (floor), and each accumulator is 20-bit signed.
REQ-023 MAC: if idx==NUM_VOICES-1 the block SHALL go to DONE; otherwise it SHALL increment idx and return to REQ.
REQ-024 DONE: each accumulator SHALL be saturated to [-32768, 32767] and registered into left_out and right_out; the block SHALL then return to IDLE.
REQ-025 left_out and right_out SHALL change only at the DONE→IDLE transition and SHALL otherwise hold their values.
REQ-026 With zero-wait voice_valid, the new outputs SHALL be visible 2*NUM_VOICES+2 clks after the sample_req cycle (18 clks for NUM_VOICES=8).
REQ-027 A sample_req arriving while busy=1 SHALL be dropped, SHALL pulse overrun for one clk, and SHALL NOT disturb the mix in progress.
REQ-028 A sample_req arriving in the same cycle as the DONE→IDLE transition SHALL be treated as an overrun.
REQ-029 busy SHALL be 1 in the REQ, MAC and DONE states.

Reset
REQ-030 While rst_n=0 the following SHALL apply on every clk edge:
- state is IDLE and idx is 0;
- acc_l and acc_r are 0;
- left_out, right_out, voice_req, voice_idx, busy, overrun and clip are all 0.
REQ-031 Asserting reset mid-mix SHALL abort the mix immediately; no partial result SHALL reach the outputs.

Configuration
REQ-032 With macro MIXER_CLIP_DETECT_EN defined:
- clip SHALL set when the DONE saturation clamps either channel;
- clip SHALL clear when clip_clr=1;
- if set and clear occur in the same cycle, set SHALL win.
REQ-033 With MIXER_CLIP_DETECT_EN undefined, clip SHALL be a constant 0, clip_clr SHALL be ignored, and no clip logic SHALL be built.

Verification
REQ-034 Reset: hold rst_n=0 for 4 clks → all outputs are 0, busy=0, and voice_req=0.
REQ-035 Single voice: voice 0 has sample 0x4000, vol_l=255 and vol_r=128; all other voices have sample 0.
- The bench pulses sample_req and holds voice_valid high.
- Required response: left_out=0x3FC0 and right_out=0x2000 exactly 18 clks later.
REQ-036 Floor rounding: voice 0 has sample 0xFFFF and vol_l=255 → left_out=0xFFFF, i.e. -1 (arithmetic floor, not truncation toward zero).
REQ-037 Saturation: all 8 voices use vol=255.
- Positive case: every sample 0x7FFF → left_out=0x7FFF and right_out=0x7FFF.
- Negative case: every sample 0x8000 → left_out=0x8000 and right_out=0x8000.
- clip=1 with MIXER_CLIP_DETECT_EN defined; clip=0 without it.
- clip_clr=1 → clip=0 on the next clk.
REQ-038 Stall and overrun:
- Delaying voice_valid by 3 clks on voice 2 → voice_req stays 1 with voice_idx=2 throughout, and the result is unchanged but arrives 3 clks later.
- A sample_req 5 clks into a mix → overrun pulses for 1 clk, and the outputs match the un-interrupted mix.
REQ-039 Reset mid-mix: assert rst_n=0 at clk 7 of a mix → left_out and right_out are 0, the block is in IDLE, and the next sample_req starts a clean mix.

Source files
------------

// File: rtl/audio_mixer.sv
// Multi-voice stereo mixer: fetches NUM_VOICES samples per sample_req, applies per-channel gains,
// and presents a saturated stereo pair. Optional sticky clip flag under MIXER_CLIP_DETECT_EN.
module audio_mixer #(
  parameter int unsigned NUM_VOICES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_req,
  output logic               voice_req,
  output logic [2:0]         voice_idx,
  input  logic               voice_valid,
  input  logic signed [15:0] voice_sample,
  input  logic [7:0]         voice_vol_l,
  input  logic [7:0]         voice_vol_r,
  output logic signed [15:0] left_out,
  output logic signed [15:0] right_out,
  output logic               busy,
  output logic               overrun,
  output logic               clip,
  input  logic               clip_clr
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SAMP_W = 16;
  localparam int unsigned VOL_W  = 8;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned PROD_W = SAMP_W + VOL_W + 1;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = 20'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -20'sd32768;

  typedef enum logic [1:0] {IDLE, REQ, MAC, DONE} state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic                      voice_req_nxt, busy_nxt, overrun_nxt;
  logic signed [SAMP_W-1:0]  sample_q;
  logic [VOL_W-1:0]          vol_l_q, vol_r_q;
  logic signed [ACC_W-1:0]   acc_l, acc_r;
  logic signed [PROD_W-1:0]  prod_l, prod_r;
  logic signed [ACC_W-1:0]   term_l, term_r;
  logic signed [SAMP_W-1:0]  sat_l, sat_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (sample_req) begin
        state_nxt = REQ;
        idx_nxt   = '0;
      end
      REQ:  if (voice_valid) state_nxt = MAC;
      MAC:  if (idx == LAST_IDX) begin
        state_nxt = DONE;
      end else begin
        idx_nxt   = idx + IDX_W'(1);
        state_nxt = REQ;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, computed from the next state so the flops line up with the state register
  always_comb begin
    voice_req_nxt = (state_nxt == REQ);
    busy_nxt      = (state_nxt != IDLE);
    overrun_nxt   = sample_req && (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      voice_req <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      voice_req <= voice_req_nxt;
      busy      <= busy_nxt;
      overrun   <= overrun_nxt;
    end
  end

  assign voice_idx = idx;

  // Gain products (floor shift) and output saturation
  always_comb begin
    prod_l = PROD_W'(sample_q) * PROD_W'($signed({1'b0, vol_l_q}));
    prod_r = PROD_W'(sample_q) * PROD_W'($signed({1'b0, vol_r_q}));
    term_l = ACC_W'(prod_l >>> 8);
    term_r = ACC_W'(prod_r >>> 8);
    sat_l  = (acc_l > SAT_MAX) ? 16'sh7FFF : (acc_l < SAT_MIN) ? 16'sh8000 : acc_l[SAMP_W-1:0];
    sat_r  = (acc_r > SAT_MAX) ? 16'sh7FFF : (acc_r < SAT_MIN) ? 16'sh8000 : acc_r[SAMP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q  <= '0;
      vol_l_q   <= '0;
      vol_r_q   <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      left_out  <= '0;
      right_out <= '0;
    end else begin
      case (state)
        IDLE: if (sample_req) begin
          acc_l <= '0;
          acc_r <= '0;
        end
        REQ: if (voice_valid) begin
          sample_q <= voice_sample;
          vol_l_q  <= voice_vol_l;
          vol_r_q  <= voice_vol_r;
        end
        MAC: begin
          acc_l <= acc_l + term_l;
          acc_r <= acc_r + term_r;
        end
        DONE: begin
          left_out  <= sat_l;
          right_out <= sat_r;
        end
        default: ;
      endcase
    end
  end

`ifdef MIXER_CLIP_DETECT_EN
  logic clip_set;

  // Sticky clip: a clamp in DONE takes priority over clip_clr
  always_comb begin
    clip_set = (state == DONE) &&
               ((acc_l > SAT_MAX) || (acc_l < SAT_MIN) || (acc_r > SAT_MAX) || (acc_r < SAT_MIN));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        clip <= 1'b0;
    else if (clip_set) clip <= 1'b1;
    else if (clip_clr) clip <= 1'b0;
  end
`else
  logic unused_clip_clr;
  assign unused_clip_clr = clip_clr;
  assign clip            = 1'b0;
`endif

endmodule
